// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing the bridge read channel between icache and dcache,
// with a pass-through write channel that blocks reads to the line being written.
module mem_rd_arbiter #(
    parameter int LINE_WIDTH        = 256,
    parameter int LINE_OFFSET_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  i_rd_req,
    input  logic [2:0]            i_rd_type,
    input  logic [31:0]           i_rd_addr,
    output logic                  i_rd_rdy,
    output logic                  i_ret_valid,
    output logic                  i_ret_last,
    output logic [31:0]           i_ret_data,

    input  logic                  d_rd_req,
    input  logic [2:0]            d_rd_type,
    input  logic [31:0]           d_rd_addr,
    output logic                  d_rd_rdy,
    output logic                  d_ret_valid,
    output logic                  d_ret_last,
    output logic [31:0]           d_ret_data,

    input  logic                  d_wr_req,
    input  logic [2:0]            d_wr_type,
    input  logic [31:0]           d_wr_addr,
    input  logic [3:0]            d_wr_wstrb,
    input  logic [LINE_WIDTH-1:0] d_wr_data,
    output logic                  d_wr_rdy,

    output logic                  mem_rd_req,
    output logic [2:0]            mem_rd_type,
    output logic [31:0]           mem_rd_addr,
    output logic                  mem_rd_id,
    input  logic                  mem_rd_rdy,
    input  logic                  mem_ret_valid,
    input  logic                  mem_ret_last,
    input  logic [31:0]           mem_ret_data,

    output logic                  mem_wr_req,
    output logic [2:0]            mem_wr_type,
    output logic [31:0]           mem_wr_addr,
    output logic [3:0]            mem_wr_wstrb,
    output logic [LINE_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_wr_rdy,
    input  logic                  mem_wr_done,

    output logic [1:0]            rd_state
);

    // Handshakes: a transfer happens in any cycle where req and rdy are both high;
    // the requester holds req and its fields stable until it sees rdy.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_state_t;

    rd_state_t   state, state_nxt;
    logic        grant_id;      // 1 = icache, 0 = dcache
    logic        last_grant;
    logic [2:0]  type_reg;
    logic [31:0] addr_reg;
    logic        wr_pending;
    logic [31:0] wr_addr_reg;

    logic        do_grant;
    logic        grant_sel;
    logic        wr_hs;
    logic        i_hazard, d_hazard;
    logic        i_elig, d_elig;

    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
        return a[31:LINE_OFFSET_WIDTH] == b[31:LINE_OFFSET_WIDTH];
    endfunction

    assign wr_hs    = d_wr_req & d_wr_rdy;
    // A read may not overtake the write in flight, nor the one being accepted now.
    assign i_hazard = (wr_pending & same_line(i_rd_addr, wr_addr_reg)) |
                      (wr_hs & same_line(i_rd_addr, d_wr_addr));
    assign d_hazard = (wr_pending & same_line(d_rd_addr, wr_addr_reg)) |
                      (wr_hs & same_line(d_rd_addr, d_wr_addr));
    assign i_elig   = i_rd_req & ~i_hazard;
    assign d_elig   = d_rd_req & ~d_hazard;

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        grant_sel = 1'b0;
        case (state)
            IDLE: begin
                if (i_elig & d_elig) begin
                    do_grant  = 1'b1;
                    grant_sel = ~last_grant;
                end else if (i_elig | d_elig) begin
                    do_grant  = 1'b1;
                    grant_sel = i_elig;
                end
                if (do_grant) state_nxt = ADDR;
            end
            ADDR: if (mem_rd_rdy) state_nxt = DATA;
            DATA: if (mem_ret_valid & mem_ret_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            type_reg    <= 3'd0;
            addr_reg    <= 32'd0;
            wr_pending  <= 1'b0;
            wr_addr_reg <= 32'd0;
        end else begin
            state <= state_nxt;
            if (do_grant) begin
                grant_id   <= grant_sel;
                last_grant <= grant_sel;
                type_reg   <= grant_sel ? i_rd_type : d_rd_type;
                addr_reg   <= grant_sel ? i_rd_addr : d_rd_addr;
            end
            if (wr_pending && mem_wr_done) begin
                wr_pending <= 1'b0;
            end else if (wr_hs) begin
                wr_pending  <= 1'b1;
                wr_addr_reg <= d_wr_addr;
            end
        end
    end

    assign rd_state    = state;
    assign mem_rd_req  = (state == ADDR);
    assign mem_rd_type = type_reg;
    assign mem_rd_addr = addr_reg;
    assign mem_rd_id   = grant_id;

    assign i_rd_rdy    = (state == ADDR) & mem_rd_rdy & grant_id;
    assign d_rd_rdy    = (state == ADDR) & mem_rd_rdy & ~grant_id;
    assign i_ret_valid = (state == DATA) & mem_ret_valid & grant_id;
    assign d_ret_valid = (state == DATA) & mem_ret_valid & ~grant_id;
    assign i_ret_last  = (state == DATA) & mem_ret_last & grant_id;
    assign d_ret_last  = (state == DATA) & mem_ret_last & ~grant_id;
    assign i_ret_data  = mem_ret_data;
    assign d_ret_data  = mem_ret_data;

    assign mem_wr_req   = d_wr_req & ~wr_pending;
    assign d_wr_rdy     = mem_wr_rdy & ~wr_pending;
    assign mem_wr_type  = d_wr_type;
    assign mem_wr_addr  = d_wr_addr;
    assign mem_wr_wstrb = d_wr_wstrb;
    assign mem_wr_data  = d_wr_data;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: arbitration order, return routing,
// write/read line hazards and mid-transaction reset.
module tb_mem_rd_arbiter;

    logic          clk = 1'b0;
    logic          resetn;
    logic          i_rd_req, d_rd_req;
    logic [2:0]    i_rd_type, d_rd_type;
    logic [31:0]   i_rd_addr, d_rd_addr;
    logic          i_rd_rdy, d_rd_rdy;
    logic          i_ret_valid, d_ret_valid, i_ret_last, d_ret_last;
    logic [31:0]   i_ret_data, d_ret_data;
    logic          d_wr_req;
    logic [2:0]    d_wr_type;
    logic [31:0]   d_wr_addr;
    logic [3:0]    d_wr_wstrb;
    logic [255:0]  d_wr_data;
    logic          d_wr_rdy;
    logic          mem_rd_req;
    logic [2:0]    mem_rd_type;
    logic [31:0]   mem_rd_addr;
    logic          mem_rd_id;
    logic          mem_rd_rdy, mem_ret_valid, mem_ret_last;
    logic [31:0]   mem_ret_data;
    logic          mem_wr_req;
    logic [2:0]    mem_wr_type;
    logic [31:0]   mem_wr_addr;
    logic [3:0]    mem_wr_wstrb;
    logic [255:0]  mem_wr_data;
    logic          mem_wr_rdy, mem_wr_done;
    logic [1:0]    rd_state;

    int n_cmp = 0;
    int n_err = 0;

    mem_rd_arbiter #(.LINE_WIDTH(256), .LINE_OFFSET_WIDTH(5)) dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .d_ret_data(d_ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
        .mem_rd_id(mem_rd_id), .mem_rd_rdy(mem_rd_rdy),
        .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
        .mem_ret_data(mem_ret_data),
        .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
        .mem_wr_wstrb(mem_wr_wstrb), .mem_wr_data(mem_wr_data),
        .mem_wr_rdy(mem_wr_rdy), .mem_wr_done(mem_wr_done),
        .rd_state(rd_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a grant, check it, complete the address phase, then feed nbeats.
    task automatic serve(input logic exp_id, input logic [31:0] exp_addr,
                         input logic [2:0] exp_type, input int nbeats, input bit drop);
        int t = 0;
        while (!mem_rd_req && t < 20) begin
            tick();
            t++;
        end
        check("rd_req_seen", mem_rd_req, 1);
        check("rd_id", mem_rd_id, exp_id);
        check("rd_addr", mem_rd_addr, exp_addr);
        check("rd_type", mem_rd_type, exp_type);
        mem_rd_rdy = 1'b1;
        #1;
        check("i_rd_rdy", i_rd_rdy, exp_id);
        check("d_rd_rdy", d_rd_rdy, !exp_id);
        tick();
        mem_rd_rdy = 1'b0;
        if (drop) begin
            if (exp_id) i_rd_req = 1'b0;
            else        d_rd_req = 1'b0;
        end
        for (int k = 0; k < nbeats; k++) begin
            mem_ret_valid = 1'b1;
            mem_ret_last  = (k == nbeats - 1);
            mem_ret_data  = {exp_addr[15:0], 16'(k)};
            #1;
            check("ret_valid_win", exp_id ? i_ret_valid : d_ret_valid, 1);
            check("ret_valid_oth", exp_id ? d_ret_valid : i_ret_valid, 0);
            check("ret_last", exp_id ? i_ret_last : d_ret_last, (k == nbeats - 1));
            check("ret_data", exp_id ? i_ret_data : d_ret_data, {exp_addr[15:0], 16'(k)});
            tick();
        end
        mem_ret_valid = 1'b0;
        mem_ret_last  = 1'b0;
    endtask

    task automatic pulse_wr_done();
        mem_wr_done = 1'b1;
        tick();
        mem_wr_done = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
        d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
        d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = '0;
        mem_rd_rdy = 0; mem_ret_valid = 0; mem_ret_last = 0; mem_ret_data = 0;
        mem_wr_rdy = 0; mem_wr_done = 0;
        tick();
        tick();
        check("rst_mem_rd_req", mem_rd_req, 0);
        check("rst_mem_rd_id", mem_rd_id, 0);
        check("rst_mem_rd_addr", mem_rd_addr, 0);
        check("rst_mem_rd_type", mem_rd_type, 0);
        check("rst_rd_rdy", {i_rd_rdy, d_rd_rdy}, 0);
        check("rst_ret", {i_ret_valid, d_ret_valid, i_ret_last, d_ret_last}, 0);
        check("rst_wr", {d_wr_rdy, mem_wr_req}, 0);
        check("rst_state", rd_state, 0);
        resetn = 1'b1;
        tick();

        // Single icache line read: grant visible the cycle after the request.
        i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1c00_0040;
        #1;
        check("t1_no_req_yet", mem_rd_req, 0);
        tick();
        check("t1_req_next", mem_rd_req, 1);
        serve(1'b1, 32'h1c00_0040, 3'b100, 8, 1'b1);
        check("t1_idle_after", rd_state, 0);

        // Both ports requesting: dcache first since last_grant resets to icache.
        d_rd_req = 1; d_rd_type = 3'b000; d_rd_addr = 32'h0000_0100;
        i_rd_req = 1; i_rd_type = 3'b000; i_rd_addr = 32'h0000_0200;
        serve(1'b0, 32'h0000_0100, 3'b000, 1, 1'b0);
        serve(1'b1, 32'h0000_0200, 3'b000, 1, 1'b0);
        serve(1'b0, 32'h0000_0100, 3'b000, 1, 1'b0);
        serve(1'b1, 32'h0000_0200, 3'b000, 1, 1'b0);
        i_rd_req = 0; d_rd_req = 0;
        tick();

        // Dcache write, then a same-line read is held while icache proceeds.
        d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h8000_1000;
        d_wr_wstrb = 4'hf; d_wr_data = {224'd0, 32'hdead_beef}; mem_wr_rdy = 1;
        #1;
        check("wr1_req", mem_wr_req, 1);
        check("wr1_rdy", d_wr_rdy, 1);
        check("wr1_addr", mem_wr_addr, 32'h8000_1000);
        check("wr1_data", mem_wr_data[31:0], 32'hdead_beef);
        tick();
        d_wr_req = 0;
        d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h8000_1010;
        i_rd_req = 1; i_rd_type = 3'b000; i_rd_addr = 32'h8000_2000;
        serve(1'b1, 32'h8000_2000, 3'b000, 1, 1'b1);
        tick(); tick(); tick();
        check("hz_hold", mem_rd_req, 0);
        d_wr_req = 1; d_wr_addr = 32'h9000_0000; d_wr_data = {224'd0, 32'h1234_5678};
        #1;
        check("wr2_blocked_req", mem_wr_req, 0);
        check("wr2_blocked_rdy", d_wr_rdy, 0);
        pulse_wr_done();
        check("wr2_accept_req", mem_wr_req, 1);
        check("wr2_accept_rdy", d_wr_rdy, 1);
        check("hz_no_grant_yet", mem_rd_req, 0);
        tick();
        d_wr_req = 0;
        check("hz_grant_after_done", mem_rd_req, 1);
        serve(1'b0, 32'h8000_1010, 3'b100, 8, 1'b1);
        pulse_wr_done();

        // Uncached single beat; a waiting request is granted two cycles after last.
        i_rd_req = 1; i_rd_type = 3'b010; i_rd_addr = 32'h1c00_0100;
        tick();
        check("unc_req", mem_rd_req, 1);
        mem_rd_rdy = 1;
        tick();
        mem_rd_rdy = 0; i_rd_req = 0;
        d_rd_req = 1; d_rd_type = 3'b000; d_rd_addr = 32'h0000_0300;
        mem_ret_valid = 1; mem_ret_last = 1; mem_ret_data = 32'h0bad_f00d;
        #1;
        check("unc_beat_last", {i_ret_valid, i_ret_last}, 2'b11);
        check("unc_beat_data", i_ret_data, 32'h0bad_f00d);
        tick();
        mem_ret_valid = 0; mem_ret_last = 0;
        check("unc_idle_m1", rd_state, 0);
        check("unc_no_req_m1", mem_rd_req, 0);
        tick();
        check("unc_req_m2", mem_rd_req, 1);
        serve(1'b0, 32'h0000_0300, 3'b000, 1, 1'b1);

        // Reset during DATA drops the transaction; bridge input held active.
        i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1c00_0040;
        mem_wr_rdy = 0;
        tick();
        mem_rd_rdy = 1;
        tick();
        mem_rd_rdy = 0; i_rd_req = 0;
        mem_ret_valid = 1; mem_ret_data = 32'h5555_aaaa;
        #1;
        check("rst_pre_valid", i_ret_valid, 1);
        resetn = 0;
        tick();
        check("rst_mid_ret", {i_ret_valid, d_ret_valid, i_ret_last, d_ret_last}, 0);
        check("rst_mid_rd", {mem_rd_req, mem_rd_id, i_rd_rdy, d_rd_rdy}, 0);
        check("rst_mid_addr", mem_rd_addr, 0);
        check("rst_mid_wr", {d_wr_rdy, mem_wr_req}, 0);
        check("rst_mid_state", rd_state, 0);
        resetn = 1; mem_ret_valid = 0;
        tick();

        // Write accepted and same-line read in the same cycle: read must wait.
        mem_wr_rdy = 1;
        d_wr_req = 1; d_wr_addr = 32'ha000_0000;
        i_rd_req = 1; i_rd_type = 3'b000; i_rd_addr = 32'ha000_0008;
        #1;
        check("same_cyc_wr_rdy", d_wr_rdy, 1);
        tick();
        d_wr_req = 0;
        check("same_cyc_no_grant", mem_rd_req, 0);
        tick();
        check("same_cyc_hold", mem_rd_req, 0);
        pulse_wr_done();
        serve(1'b1, 32'ha000_0008, 3'b000, 1, 1'b1);

        // Fresh dcache read after reset behaves normally.
        d_rd_req = 1; d_rd_type = 3'b000; d_rd_addr = 32'h0000_0400;
        serve(1'b0, 32'h0000_0400, 3'b000, 1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter

Shares the single memory-side read channel and the single write channel of the AXI bridge between the instruction cache and the data cache. It accepts one cache-line or uncached read at a time from either requester, selects between them with round-robin, and routes the return beats back to the winner. It tracks the one outstanding data-cache write and holds off any read to the same cache line until that write has completed. It sits between the two caches and the AXI bridge.

## Interface
- LINE_WIDTH, 256, cache line width in bits (write data)
- LINE_OFFSET_WIDTH, 5, byte-offset bits within a line; line address = addr[31:LINE_OFFSET_WIDTH]

- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- i_rd_req / d_rd_req  in  1  read request from icache / dcache
- i_rd_type / d_rd_type  in  3  read type (3'b100 = line burst; 3'b0xx = single uncached beat)
- i_rd_addr / d_rd_addr  in  32  read address
- i_rd_rdy / d_rd_rdy  out  1  read address accepted (one-cycle pulse)
- i_ret_valid / d_ret_valid  out  1  return beat valid for that requester
- i_ret_last / d_ret_last  out  1  last return beat
- i_ret_data / d_ret_data  out  32  return data (mem_ret_data broadcast)
- d_wr_req  in  1  dcache write request
- d_wr_type  in  3  write type
- d_wr_addr  in  32  write address
- d_wr_wstrb  in  4  byte strobes (uncached writes)
- d_wr_data  in  LINE_WIDTH  write data
- d_wr_rdy  out  1  write accepted
- mem_rd_req  out  1  read request to bridge
- mem_rd_type  out  3  granted type
- mem_rd_addr  out  32  granted address
- mem_rd_id  out  1  granted requester (0 = dcache, 1 = icache)
- mem_rd_rdy  in  1  bridge accepts read address
- mem_ret_valid / mem_ret_last  in  1  return beat / last beat
- mem_ret_data  in  32  return data
- mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data  out  as d_wr_*  write to bridge
- mem_wr_rdy  in  1  bridge accepts write
- mem_wr_done  in  1  write response received (one-cycle pulse)

## Operation
- Read FSM states: IDLE, ADDR, DATA. Reset: IDLE, last_grant = icache, wr_pending = 0.
- IDLE: eligible(p) = p_rd_req & !hazard(p). If both eligible, grant the port not equal to last_grant; else grant the single eligible port. On a grant, latch type/addr/id, set last_grant, go to ADDR. No eligible port: stay in IDLE.
- ADDR: mem_rd_req = 1 with latched fields. On mem_rd_rdy, pulse granted p_rd_rdy the same cycle (combinational from mem_rd_rdy) and go to DATA. Requester holds req/addr stable until rd_rdy.
- DATA: p_ret_valid = mem_ret_valid, p_ret_last = mem_ret_last for the granted port only; the other port sees 0. On mem_ret_valid & mem_ret_last go to IDLE.
- Hazard: hazard(p) = line(p_rd_addr) == line(wr_addr_reg) & wr_pending, or line(p_rd_addr) == line(d_wr_addr) & d_wr_req & d_wr_rdy in the same cycle.
- Write path: mem_wr_* = d_wr_* pass-through. mem_wr_req = d_wr_req & !wr_pending. d_wr_rdy = mem_wr_rdy & !wr_pending. A handshake sets wr_pending and latches wr_addr_reg. mem_wr_done clears wr_pending. mem_wr_done while not pending is ignored.
- Reset mid-transaction returns to IDLE and drops the outstanding transaction. The bridge is reset with it.

## Timing
- Reset values of all outputs: i/d_rd_rdy = 0, i/d_ret_valid = 0, i/d_ret_last = 0, mem_rd_req = 0, mem_rd_id = 0, mem_rd_type/addr = 0, d_wr_rdy = 0, mem_wr_req = 0.
- Request seen in IDLE at cycle N gives mem_rd_req at N+1. The earliest rd_rdy is N+1.
- Return latency adds zero cycles: ret outputs are combinational from mem_ret_*.
- After ret_last at cycle M the FSM is in IDLE at M+1. The earliest next mem_rd_req is M+2.
- A write handshake and a read grant in the same cycle are both allowed unless the line addresses match.

## Test plan
- Single icache line read at 0x1c000040: i_rd_req -> mem_rd_req next cycle with addr 0x1c000040, id 1. 8 beats route to i_ret_*. d_ret_valid stays 0 throughout.
- Both ports request continuously from reset: grants alternate d, i, d, i. mem_rd_id sequence is 0, 1, 0, 1.
- Dcache write to 0x80001000 accepted, then d_rd_req to 0x80001010 -> no grant until mem_wr_done. Grant follows the next cycle. A concurrent i_rd_req to 0x80002000 is granted meanwhile.
- Second d_wr_req while wr_pending -> d_wr_rdy = 0 and mem_wr_req = 0 until mem_wr_done. Then accepted.
- Uncached read, type 3'b010: one beat with ret_last -> FSM returns to IDLE. The next request is granted 2 cycles later.
- Assert resetn low during DATA -> all outputs 0 the next cycle. A fresh request after reset works normally.
